mem_access_sequencer: RTL and testbench

- Sequences the byte-split memory block (memH/memL) and drives its ctrl, memRd, memWr, I, ir_wr, mdr_l and mdr_h controls.
- Arbitrates between two requesters: the instruction-fetch requester (PC → IR, word) and the data requester (load/store through R6 or AluOut, word or byte).
- Sits between the control unit and the memory block. The control unit issues requests and waits for acks instead of hand-timing the memory strobes.

---
 rtl/mem_access_sequencer_if.sv | 30 +++
 rtl/mem_access_sequencer.sv | 120 ++++++++++++
 tb/tb_mem_access_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_sequencer_if.sv
// Request/strobe bundle between the control unit, the memory access sequencer
// and the byte-split memory block (memH/memL).
interface mem_access_sequencer_if;
    logic       fetch_req;
    logic       fetch_ack;
    logic       data_req;
    logic       data_we;
    logic [1:0] data_size;
    logic       data_asel;
    logic       data_ack;
    logic       busy;
    logic       ctrl;
    logic       memRd;
    logic       memWr;
    logic [1:0] I;
    logic       ir_wr;
    logic       mdr_l;
    logic       mdr_h;

    // control-unit side: raises requests, consumes acks and observes strobes
    modport master (
        output fetch_req, data_req, data_we, data_size, data_asel,
        input  fetch_ack, data_ack, busy, ctrl, memRd, memWr, I, ir_wr, mdr_l, mdr_h
    );

    modport slave (
        input  fetch_req, data_req, data_we, data_size, data_asel,
        output fetch_ack, data_ack, busy, ctrl, memRd, memWr, I, ir_wr, mdr_l, mdr_h
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Arbitrates instruction fetch vs. data load/store and sequences memH/memL strobes.
// MEM_RR_ARB_EN selects strict alternation on contention instead of data priority.
module mem_access_sequencer #(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 3
) (
    input logic                   clock,
    input logic                   reset,
    mem_access_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_t;

    state_t     state, state_nxt;
    logic [2:0] rd_cnt;
    logic       rd_last;
    logic [1:0] size_q;
    logic       asel_q;
    logic [1:0] i_q;
    logic       grant_f, grant_d;
    logic       word;

`ifdef MEM_RR_ARB_EN
    logic last_data;

    assign grant_f = (state == IDLE) && bus.fetch_req && (!bus.data_req || last_data);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        last_data <= 1'b1;
        else if (grant_f) last_data <= 1'b0;
        else if (grant_d) last_data <= 1'b1;
    end
`else
    logic [3:0] starv;

    assign grant_f = (state == IDLE) && bus.fetch_req &&
                     (!bus.data_req || starv == 4'(MAX_WAIT));

    always_ff @(posedge clock or posedge reset) begin
        if (reset)        starv <= 4'd0;
        else if (grant_f) starv <= 4'd0;
        else if (grant_d && bus.fetch_req && starv != 4'(MAX_WAIT))
            starv <= starv + 4'd1;
    end
`endif

    assign grant_d = (state == IDLE) && bus.data_req && !grant_f;
    assign rd_last = (rd_cnt == 3'(RD_LAT - 1));
    assign word    = size_q[1];
    // address select is registered at grant and held through IDLE
    assign bus.I   = i_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            rd_cnt <= 3'd0;
            size_q <= 2'b00;
            asel_q <= 1'b0;
            i_q    <= 2'b10;
        end else begin
            state  <= state_nxt;
            rd_cnt <= ((state == FETCH || state == DREAD) && !rd_last) ? rd_cnt + 3'd1 : 3'd0;
            if (grant_f) i_q <= 2'b10;
            if (grant_d) begin
                size_q <= bus.data_size;
                asel_q <= bus.data_asel;
                i_q    <= {1'b0, bus.data_asel};
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.fetch_ack = 1'b0;
        bus.data_ack  = 1'b0;
        bus.ctrl      = 1'b0;
        bus.memRd     = 1'b0;
        bus.memWr     = 1'b0;
        bus.ir_wr     = 1'b0;
        bus.mdr_l     = 1'b0;
        bus.mdr_h     = 1'b0;
        bus.busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_f)      state_nxt = FETCH;
                else if (grant_d) state_nxt = bus.data_we ? DWRITE : DREAD;
            end
            FETCH: begin
                bus.memRd = 1'b1;
                bus.ctrl  = 1'b1;
                if (rd_last) begin
                    bus.ir_wr     = 1'b1;
                    bus.fetch_ack = 1'b1;
                    state_nxt     = IDLE;
                end
            end
            DREAD: begin
                bus.memRd = 1'b1;
                bus.ctrl  = word;
                if (rd_last) begin
                    // size 00 = low byte, 01 = high byte, 1x = word
                    bus.mdr_l    = word || !size_q[0];
                    bus.mdr_h    = word ||  size_q[0];
                    bus.data_ack = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            DWRITE: begin
                bus.memWr    = 1'b1;
                bus.ctrl     = word;
                bus.data_ack = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // asel only matters through i_q; keep the latched copy for visibility
    logic unused_asel;
    assign unused_asel = asel_q;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Randomized + directed bench for mem_access_sequencer against a transaction-level model.
module tb_mem_access_sequencer;
    localparam int RD_LAT   = 3;
    localparam int MAX_WAIT = 3;
    localparam int K_NONE = 0, K_FETCH = 1, K_READ = 2, K_WRITE = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mem_access_sequencer_if mif ();

    mem_access_sequencer #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (mif.slave)
    );

    // ---- transaction-level model: one outstanding access with a cycle budget
    int         m_kind      = K_NONE;
    int         m_left      = 0;
    int         m_starv     = 0;
    bit         m_last_data = 1'b1;
    logic [1:0] m_I         = 2'b10;
    logic [1:0] m_size      = 2'b00;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_kind <= K_NONE; m_left <= 0; m_starv <= 0; m_last_data <= 1'b1; m_I <= 2'b10;
        end else if (m_kind != K_NONE) begin
            if (m_left == 1) m_kind <= K_NONE;
            m_left <= m_left - 1;
        end else begin
`ifdef MEM_RR_ARB_EN
            if (mif.fetch_req && (!mif.data_req || m_last_data)) begin
`else
            if (mif.fetch_req && (!mif.data_req || m_starv == MAX_WAIT)) begin
`endif
                m_kind <= K_FETCH; m_left <= RD_LAT; m_I <= 2'b10;
                m_starv <= 0; m_last_data <= 1'b0;
            end else if (mif.data_req) begin
                m_kind <= mif.data_we ? K_WRITE : K_READ;
                m_left <= mif.data_we ? 1 : RD_LAT;
                m_size <= mif.data_size;
                m_I    <= {1'b0, mif.data_asel};
                m_last_data <= 1'b1;
                if (mif.fetch_req && m_starv < MAX_WAIT) m_starv <= m_starv + 1;
            end
        end
    end

    // {busy, fetch_ack, data_ack, ctrl, memRd, memWr, I[1:0], ir_wr, mdr_l, mdr_h}
    function automatic logic [10:0] mdl_vec();
        bit last, word, fa, da;
        last = (m_kind != K_NONE) && (m_left == 1);
        word = m_size[1];
        fa   = last && m_kind == K_FETCH;
        da   = last && (m_kind == K_READ || m_kind == K_WRITE);
        return {m_kind != K_NONE, fa, da,
                m_kind == K_FETCH || ((m_kind == K_READ || m_kind == K_WRITE) && word),
                m_kind == K_FETCH || m_kind == K_READ, m_kind == K_WRITE, m_I, fa,
                last && m_kind == K_READ && (word || m_size == 2'b00),
                last && m_kind == K_READ && (word || m_size == 2'b01)};
    endfunction

    function automatic logic [10:0] act_vec();
        return {mif.busy, mif.fetch_ack, mif.data_ack, mif.ctrl, mif.memRd, mif.memWr,
                mif.I, mif.ir_wr, mif.mdr_l, mif.mdr_h};
    endfunction

    // ---- single compare process: model every cycle, plus queued literal pins
    typedef struct {
        string       name;
        logic [10:0] v;
        bit          is_order;
        string       want;
    } lit_t;

    lit_t  litq[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    bit    log_en = 1'b0;
    string ack_log = "";

    always @(negedge clock) begin
        int          c, p;
        logic [10:0] a, e;
        lit_t        l;
        c = 1; p = 0;
        a = act_vec();
        e = mdl_vec();
        if (a == e) p = 1;
        else $display("FAIL model_cycle t=%0t: got %b want %b", $time, a, e);
        while (litq.size() > 0) begin
            l = litq.pop_front();
            c = c + 1;
            if (l.is_order) begin
                if (ack_log == l.want) p = p + 1;
                else $display("FAIL %s: got %s want %s", l.name, ack_log, l.want);
            end else if (a == l.v) p = p + 1;
            else $display("FAIL %s: got %b want %b", l.name, a, l.v);
        end
        if (log_en && mif.fetch_ack) ack_log <= {ack_log, "F"};
        if (log_en && mif.data_ack)  ack_log <= {ack_log, "D"};
        n_chk  <= n_chk + c;
        n_pass <= n_pass + p;
    end

    // ---- stimulus
    task automatic tick();
        @(posedge clock); #1;
    endtask

    task automatic nxt();
        @(negedge clock); #1;
    endtask

    task automatic pin(input string n, input logic [10:0] v);
        lit_t l;
        l.name = n; l.v = v; l.is_order = 1'b0; l.want = "";
        litq.push_back(l);
    endtask

    initial begin
        lit_t ol;
        mif.fetch_req = 1'b0; mif.data_req = 1'b0;
        mif.data_we = 1'b0; mif.data_size = 2'b00; mif.data_asel = 1'b0;
        #1 reset = 1'b1;
        pin("reset_state", 11'b0_0_0_0_0_0_10_0_0_0);
        #11 reset = 1'b0;

        // lone fetch
        tick(); mif.fetch_req = 1'b1;
        tick(); pin("fetch_c1",   11'b1_0_0_1_1_0_10_0_0_0);
        nxt();  pin("fetch_c2",   11'b1_0_0_1_1_0_10_0_0_0);
        nxt();  pin("fetch_last", 11'b1_1_0_1_1_0_10_1_0_0);
        nxt();  mif.fetch_req = 1'b0;
        pin("fetch_idle", 11'b0_0_0_0_0_0_10_0_0_0);
        nxt();

        // byte-low store from R6; inputs scrambled after grant must be ignored
        mif.data_req = 1'b1; mif.data_we = 1'b1; mif.data_size = 2'b00; mif.data_asel = 1'b0;
        tick(); mif.data_we = 1'b0; mif.data_size = 2'b10; mif.data_asel = 1'b1;
        pin("byte_store", 11'b1_0_1_0_0_1_00_0_0_0);
        nxt();  mif.data_req = 1'b0;
        pin("store_idle_I_held", 11'b0_0_0_0_0_0_00_0_0_0);
        nxt();

        // word load via AluOut
        mif.data_req = 1'b1; mif.data_we = 1'b0; mif.data_size = 2'b10; mif.data_asel = 1'b1;
        tick(); pin("wload_c1",   11'b1_0_0_1_1_0_01_0_0_0);
        nxt();  pin("wload_c2",   11'b1_0_0_1_1_0_01_0_0_0);
        nxt();  pin("wload_last", 11'b1_0_1_1_1_0_01_0_1_1);
        nxt();  mif.data_req = 1'b0;
        nxt();

        // reset in the 2nd cycle of a word read
        mif.data_req = 1'b1; mif.data_we = 1'b0; mif.data_size = 2'b10; mif.data_asel = 1'b0;
        tick(); tick(); #1;
        reset = 1'b1; mif.data_req = 1'b0;
        pin("reset_mid_read", 11'b0_0_0_0_0_0_10_0_0_0);
        nxt(); tick(); reset = 1'b0;

        // contention: both requests held, record grant order from the acks
        mif.fetch_req = 1'b1; mif.data_req = 1'b1; mif.data_we = 1'b1;
        mif.data_size = 2'b00; mif.data_asel = 1'b0;
        log_en = 1'b1;
        for (int i = 0; i < 80 && ack_log.len() < 5; i++) nxt();
        mif.fetch_req = 1'b0; mif.data_req = 1'b0; log_en = 1'b0;
        ol.name = "grant_order"; ol.v = '0; ol.is_order = 1'b1;
`ifdef MEM_RR_ARB_EN
        ol.want = "FDFDF";
`else
        ol.want = "DDDFD";
`endif
        litq.push_back(ol);
        nxt(); nxt();

        // randomized requesters: hold until ack, sometimes withdraw, re-raise at random
        for (int i = 0; i < 3000; i++) begin
            nxt();
            if (mif.fetch_ack)      mif.fetch_req = ($urandom % 4) == 0;
            else if (!mif.fetch_req) mif.fetch_req = ($urandom % 3) == 0;
            else if ($urandom % 16 == 0) mif.fetch_req = 1'b0;
            if (mif.data_ack)       mif.data_req = ($urandom % 4) == 0;
            else if (!mif.data_req) mif.data_req = ($urandom % 3) == 0;
            else if ($urandom % 16 == 0) mif.data_req = 1'b0;
            mif.data_we   = $urandom % 2;
            mif.data_size = 2'($urandom % 4);
            mif.data_asel = $urandom % 2;
        end
        mif.fetch_req = 1'b0; mif.data_req = 1'b0;
        for (int i = 0; i < 8; i++) nxt();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
